vector_sweep_checker: RTL and testbench

- Parametrised, self-checking successor to the team's exhaustive truth-table stimulus sequence for small combinational gates.
- Drives every N_IN-bit input vector to a combinational DUT in binary order and holds each vector for DWELL clocks.
- Samples the DUT's 1-bit response, builds the measured truth table, compares it with an expected table, and reports pass/fail, error count and first failing vector.
- Sits beside the DUT in lab top-levels; replaces hand-written delay/assignment benches.

---
 rtl/vector_sweep_checker.sv | 187 ++++++++++++++++++
 tb/tb_vector_sweep_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sweep_checker.sv
// vector_sweep_checker: exhaustive truth-table sweep for a small combinational DUT.
// Drives vectors 0..2^N_IN-1 in order, holds each for DWELL clocks, samples the
// 1-bit response at the end of each dwell and compares it with a latched
// expected table. Results are published only when a sweep completes.
//
// state   | meaning
// S_IDLE  | waiting for start; reached from reset or abort
// S_APPLY | sweep in progress, vec driven to the DUT
// S_DONE  | single sweep finished, done held high until next start
module vector_sweep_checker #(
  parameter int N_IN  = 4,
  parameter int DWELL = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode_loop,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_cnt,
  output logic [N_IN-1:0]        first_err_vec,
  output logic                   err_valid,
  output logic [(1<<N_IN)-1:0]   truth_table
);

  localparam int NV = 1 << N_IN;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [NV-1:0]   exp_q, exp_d;
  // working (in-sweep) results; published copies below are only updated at sweep end
  logic [NV-1:0]   wtt_q, wtt_d;
  logic [N_IN:0]   werr_q, werr_d;
  logic [N_IN-1:0] wfirst_q, wfirst_d;
  logic            wfound_q, wfound_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            err_valid_q, err_valid_d;
  logic [NV-1:0]   tt_q, tt_d;

  logic            mism;
  logic [NV-1:0]   smp_tt;
  logic [N_IN:0]   smp_err;
  logic [N_IN-1:0] smp_first;
  logic            smp_found;

  // Next-state and next-output computation for the whole checker.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    dwell_d     = dwell_q;
    exp_d       = exp_q;
    wtt_d       = wtt_q;
    werr_d      = werr_q;
    wfirst_d    = wfirst_q;
    wfound_d    = wfound_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_d     = first_q;
    err_valid_d = err_valid_q;
    tt_d        = tt_q;

    // result of the current vector's sample, folded into the working state
    mism           = dut_out != exp_q[vec_q];
    smp_tt         = wtt_q;
    smp_tt[vec_q]  = dut_out;
    smp_err        = werr_q + {{N_IN{1'b0}}, mism};
    smp_first      = (mism && !wfound_q) ? vec_q : wfirst_q;
    smp_found      = wfound_q | mism;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_APPLY;
          vec_d    = '0;
          dwell_d  = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          exp_d    = expected;
          werr_d   = '0;
          wfirst_d = '0;
          wfound_d = 1'b0;
        end
      end
      S_APPLY: begin
        done_d = 1'b0;
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          vec_d   = '0;
          dwell_d = '0;
        end else if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + DW'(1);
        end else begin
          wtt_d    = smp_tt;
          werr_d   = smp_err;
          wfirst_d = smp_first;
          wfound_d = smp_found;
          dwell_d  = '0;
          if (vec_q != {N_IN{1'b1}}) begin
            vec_d = vec_q + N_IN'(1);
          end else begin
            tt_d        = smp_tt;
            err_cnt_d   = smp_err;
            pass_d      = (smp_err == '0);
            first_d     = smp_found ? smp_first : '0;
            err_valid_d = smp_found;
            done_d      = 1'b1;
            vec_d       = '0;
            if (mode_loop) begin
              exp_d    = expected;
              werr_d   = '0;
              wfirst_d = '0;
              wfound_d = 1'b0;
            end else begin
              state_d = S_DONE;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      dwell_q     <= '0;
      exp_q       <= '0;
      wtt_q       <= '0;
      werr_q      <= '0;
      wfirst_q    <= '0;
      wfound_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_q     <= '0;
      err_valid_q <= 1'b0;
      tt_q        <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      dwell_q     <= dwell_d;
      exp_q       <= exp_d;
      wtt_q       <= wtt_d;
      werr_q      <= werr_d;
      wfirst_q    <= wfirst_d;
      wfound_q    <= wfound_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_q     <= first_d;
      err_valid_q <= err_valid_d;
      tt_q        <= tt_d;
    end
  end

  assign vec           = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_vec = first_q;
  assign err_valid     = err_valid_q;
  assign truth_table   = tt_q;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Bench for vector_sweep_checker: a default (N_IN=4, DWELL=50) instance and a
// small looping instance (N_IN=2, DWELL=1). Expected sweep results come from a
// behavioural truth-table model, queued at each start and popped at each done.
module tb_vector_sweep_checker;

  typedef struct packed {
    logic        pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first;
    logic        err_valid;
    logic [15:0] tt;
  } res_t;

  logic clk, rst_n;

  logic        start, abort, mode_loop, dut_out;
  logic [15:0] expected;
  logic [3:0]  vec;
  logic        busy, done, pass, err_valid;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_vec;
  logic [15:0] truth_table;
  int          dut_sel;

  logic        start2, abort2, mode_loop2, dut_out2;
  logic [3:0]  expected2;
  logic [1:0]  vec2;
  logic        busy2, done2, pass2, err_valid2;
  logic [2:0]  err_cnt2;
  logic [1:0]  first_err_vec2;
  logic [3:0]  truth_table2;

  int   n_assert = 0;
  int   n_fail   = 0;
  res_t q1[$];
  res_t q2[$];

  // 0 = AND, 1 = OR, other = XOR of the two low bits
  function automatic logic resp(int sel, logic [3:0] v);
    case (sel)
      0:       return &v;
      1:       return |v;
      default: return v[1] ^ v[0];
    endcase
  endfunction

  function automatic res_t model(int nin, logic [15:0] exp, int sel);
    res_t r;
    logic o;
    r = '0;
    for (int v = 0; v < (1 << nin); v++) begin
      o = resp(sel, 4'(v));
      r.tt[v] = o;
      if (o != exp[v]) begin
        if (!r.err_valid) r.first = 4'(v);
        r.err_valid = 1'b1;
        r.err_cnt   = r.err_cnt + 5'd1;
      end
    end
    r.pass = (r.err_cnt == 5'd0);
    return r;
  endfunction

  assign dut_out  = resp(dut_sel, vec);
  assign dut_out2 = resp(2, {2'b00, vec2});

  vector_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_loop(mode_loop),
    .expected(expected), .dut_out(dut_out), .vec(vec), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_err_vec(first_err_vec),
    .err_valid(err_valid), .truth_table(truth_table)
  );

  vector_sweep_checker #(.N_IN(2), .DWELL(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .mode_loop(mode_loop2),
    .expected(expected2), .dut_out(dut_out2), .vec(vec2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err_cnt2), .first_err_vec(first_err_vec2),
    .err_valid(err_valid2), .truth_table(truth_table2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_empty(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: observed empty scoreboard expected queued result", tag);
  endtask

  task automatic check_res1(input string tag);
    res_t e;
    if (q1.size() == 0) begin
      sb_empty(tag);
      return;
    end
    e = q1.pop_front();
    chk({tag, "_pass"},  32'(pass),          32'(e.pass));
    chk({tag, "_err"},   32'(err_cnt),       32'(e.err_cnt));
    chk({tag, "_first"}, 32'(first_err_vec), 32'(e.first));
    chk({tag, "_valid"}, 32'(err_valid),     32'(e.err_valid));
    chk({tag, "_tt"},    32'(truth_table),   32'(e.tt));
  endtask

  task automatic check_res2(input string tag);
    res_t e;
    if (q2.size() == 0) begin
      sb_empty(tag);
      return;
    end
    e = q2.pop_front();
    chk({tag, "_pass"},  32'(pass2),          32'(e.pass));
    chk({tag, "_err"},   32'(err_cnt2),       32'(e.err_cnt));
    chk({tag, "_first"}, 32'(first_err_vec2), 32'(e.first));
    chk({tag, "_valid"}, 32'(err_valid2),     32'(e.err_valid));
    chk({tag, "_tt"},    32'(truth_table2),   32'(e.tt[3:0]));
  endtask

  task automatic start_sweep1();
    q1.push_back(model(4, expected, dut_sel));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
  endtask

  // Run from the start edge to done; optional stray start and expected change.
  task automatic wait_done1(input string tag, input int start_at, input int exp_at,
                            input logic [15:0] exp_new);
    int cnt;
    cnt = 0;
    while (!done && cnt < 1000) begin
      if (cnt % 50 == 0 && cnt < 800) chk({tag, "_vec_step"}, 32'(vec), 32'(cnt / 50));
      tick();
      cnt++;
      start = (cnt == start_at);
      if (cnt == exp_at) expected = exp_new;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cnt), 32'd800);
    check_res1(tag);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_vec_end"},  32'(vec),  32'd0);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_vec"},   32'(vec),           32'd0);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_done"},  32'(done),          32'd0);
    chk({tag, "_pass"},  32'(pass),          32'd0);
    chk({tag, "_err"},   32'(err_cnt),       32'd0);
    chk({tag, "_first"}, 32'(first_err_vec), 32'd0);
    chk({tag, "_valid"}, 32'(err_valid),     32'd0);
    chk({tag, "_tt"},    32'(truth_table),   32'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; mode_loop = 1'b0; expected = 16'h8000; dut_sel = 0;
    start2 = 1'b0; abort2 = 1'b0; mode_loop2 = 1'b0; expected2 = 4'h6;
    repeat (3) tick();
    check_reset_zero("rst");
    chk("rst_busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    tick();

    // AND gate against 16'h8000: clean pass, done held as a level
    start_sweep1();
    wait_done1("and", -1, -1, 16'h0);
    repeat (3) tick();
    chk("and_done_level", 32'(done), 32'd1);

    // OR gate against 16'h8000: 14 mismatches, first at vector 1
    dut_sel = 1;
    start_sweep1();
    wait_done1("or", -1, -1, 16'h0);

    // stray start at clock 100 and expected change at clock 200 are ignored
    dut_sel = 0;
    start_sweep1();
    wait_done1("ign", 100, 200, 16'h0000);
    expected = 16'h8000;

    // abort at clock 300 of a failing OR sweep; prior passing results retained
    dut_sel = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy),        32'd0);
    chk("abort_vec",  32'(vec),         32'd0);
    chk("abort_done", 32'(done),        32'd0);
    chk("abort_pass", 32'(pass),        32'd1);
    chk("abort_err",  32'(err_cnt),     32'd0);
    chk("abort_tt",   32'(truth_table), 32'h8000);

    // reset at clock 420 of a sweep, then a fresh sweep completes normally
    dut_sel = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (420) tick();
    rst_n = 1'b0;
    #1;
    check_reset_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    start_sweep1();
    wait_done1("rerun", -1, -1, 16'h0);

    // abort while in DONE does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_done_done", 32'(done), 32'd1);
    chk("abort_in_done_pass", 32'(pass), 32'd1);

    // DWELL=1, N_IN=2, XOR, looping: done pulses every 4 clocks, then stops
    mode_loop2 = 1'b1;
    expected2  = 4'h6;
    repeat (4) q2.push_back(model(2, 16'(expected2), 2));
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("loop_busy0", 32'(busy2), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("loop_done", 32'(done2), 32'(i % 4 == 0));
      chk("loop_busy", 32'(busy2), 32'(i < 16));
      chk("loop_vec",  32'(vec2),  32'(i % 4));
      if (done2) check_res2("loop");
      if (i == 12) mode_loop2 = 1'b0;
    end
    tick();
    chk("loop_final_done_level", 32'(done2), 32'd1);

    // every response wrong: err_cnt reaches 2^N_IN without wrap
    expected2 = 4'h9;
    q2.push_back(model(2, 16'(expected2), 2));
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cnt = 0;
    while (!done2 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("full_latency", 32'(cnt), 32'd4);
    check_res2("full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
